// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: steps one fully-connected layer pass across the packed weight ROM.
// Each feature index k reads every neuron's weight plus the matching activation. Both are
// registered into one pipeline stage that feeds the parallel MAC array. The finished result
// is then held under a valid/ready handshake.
module fc_layer_sequencer #(
   parameter int NUM_INPUTS   = 16,
   parameter int NUM_NEURONS  = 16,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACT_WIDTH    = 8,
   parameter int ADDR_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   output logic                                busy,
   output logic                                done,
   output logic [ADDR_WIDTH-1:0]               rom_addr,
   input  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] rom_data,
   output logic [ADDR_WIDTH-1:0]               in_addr,
   input  logic [ACT_WIDTH-1:0]                in_data,
   output logic                                mac_clear,
   output logic                                mac_en,
   output logic                                mac_last,
   output logic [ACT_WIDTH-1:0]                mac_act,
   output logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] mac_weights,
   output logic                                out_valid,
   input  logic                                out_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_OUT
   } state_t;

   // Index of the final feature; the counter parks here rather than wrapping.
   localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(NUM_INPUTS - 1);

   state_t                              state_q, state_d;
   logic [ADDR_WIDTH-1:0]               k_q, k_d;
   logic                                en_q, en_d;
   logic                                last_q, last_d;
   logic                                done_q, done_d;
   logic [ACT_WIDTH-1:0]                act_q, act_d;
   logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] weights_q, weights_d;

   // State register, feature counter and the single data pipeline stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         en_q      <= 1'b0;
         last_q    <= 1'b0;
         done_q    <= 1'b0;
         act_q     <= '0;
         weights_q <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         en_q      <= en_d;
         last_q    <= last_d;
         done_q    <= done_d;
         act_q     <= act_d;
         weights_q <= weights_d;
      end
   end

   // Next state, counter step and pipeline capture.
   // A RUN cycle at index k produces the MAC beat for k on the following cycle.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      en_d      = 1'b0;
      last_d    = 1'b0;
      done_d    = 1'b0;
      act_d     = act_q;
      weights_d = weights_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            k_d     = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            en_d      = 1'b1;
            act_d     = in_data;
            weights_d = rom_data;
            if (k_q == K_LAST) begin
               last_d  = 1'b1;
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + ADDR_WIDTH'(1);
            end
         end
         S_DRAIN: begin
            state_d = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs that depend only on the current state, the counter and the pipeline registers.
   always_comb begin
      busy        = (state_q != S_IDLE);
      mac_clear   = (state_q == S_CLEAR);
      out_valid   = (state_q == S_OUT);
      rom_addr    = (state_q == S_RUN) ? k_q : '0;
      in_addr     = (state_q == S_RUN) ? k_q : '0;
      mac_en      = en_q;
      mac_last    = last_q;
      mac_act     = act_q;
      mac_weights = weights_q;
      done        = done_q;
   end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Testbench for fc_layer_sequencer.
// The default build is checked every cycle against a pass-timeline model, using directed
// sequences and random traffic. A one-input build is checked from a vector table.
module tb_fc_layer_sequencer;

   localparam int N   = 16;
   localparam int NN  = 16;
   localparam int WW  = 8;
   localparam int ADW = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           out_ready = 1'b0;
   logic           busy, done, mac_clear, mac_en, mac_last, out_valid;
   logic [ADW-1:0] rom_addr, in_addr;
   logic [NN*WW-1:0] rom_data, mac_weights;
   logic [7:0]     in_data, mac_act;

   logic [NN*WW-1:0] rom_mem [N];
   logic [7:0]       act_mem [N];

   // Single-feature build, four lanes.
   logic        s_start = 1'b0;
   logic        s_ready = 1'b0;
   logic        s_busy, s_done, s_clear, s_en, s_last, s_valid;
   logic [0:0]  s_rom_addr, s_in_addr;
   logic [31:0] s_rom_data;
   logic [7:0]  s_in_data;
   logic [7:0]  s_act;
   logic [31:0] s_weights;

   int checks = 0;
   int errors = 0;
   int mt = 0;
   bit mdone = 1'b0;

   typedef struct {
      logic start;
      logic ready;
      logic busy;
      logic clear;
      logic en;
      logic last;
      logic valid;
      logic done;
   } vec_t;

   vec_t tbl [12];

   fc_layer_sequencer #(.NUM_INPUTS(N), .NUM_NEURONS(NN), .WEIGHT_WIDTH(WW), .ACT_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .rom_addr(rom_addr), .rom_data(rom_data), .in_addr(in_addr), .in_data(in_data),
      .mac_clear(mac_clear), .mac_en(mac_en), .mac_last(mac_last), .mac_act(mac_act),
      .mac_weights(mac_weights), .out_valid(out_valid), .out_ready(out_ready)
   );

   fc_layer_sequencer #(.NUM_INPUTS(1), .NUM_NEURONS(4), .WEIGHT_WIDTH(8), .ACT_WIDTH(8)) dut_small (
      .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
      .rom_addr(s_rom_addr), .rom_data(s_rom_data), .in_addr(s_in_addr), .in_data(s_in_data),
      .mac_clear(s_clear), .mac_en(s_en), .mac_last(s_last), .mac_act(s_act),
      .mac_weights(s_weights), .out_valid(s_valid), .out_ready(s_ready)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Combinational ROM and activation buffer behind the DUT addresses.
   always_comb begin
      rom_data   = rom_mem[rom_addr];
      in_data    = act_mem[in_addr];
      s_rom_data = 32'hA1B2_C3D4;
      s_in_data  = 8'h5E;
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Compare the default build against the model's position within the pass.
   // mt counts cycles since the accepted start. mt == N+3 means waiting in OUT.
   task automatic check_output();
      bit exp_en;
      exp_en = (mt >= 3 && mt <= N + 2);
      check("busy", busy, (mt != 0));
      check("mac_clear", mac_clear, (mt == 1));
      check("mac_en", mac_en, exp_en);
      check("mac_last", mac_last, (mt == N + 2));
      check("out_valid", out_valid, (mt == N + 3));
      check("done", done, mdone);
      check("rom_addr", rom_addr, (mt >= 2 && mt <= N + 1) ? mt - 2 : 0);
      check("in_addr", in_addr, (mt >= 2 && mt <= N + 1) ? mt - 2 : 0);
      if (exp_en) begin
         check("mac_act", mac_act, act_mem[mt-3]);
         check("mac_weights", mac_weights, rom_mem[mt-3]);
      end
   endtask

   // Advance one clock edge, step the model with the inputs seen at that edge, then check.
   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         mt    = 0;
         mdone = 1'b0;
      end else begin
         mdone = (mt == N + 3) && out_ready;
         if (mt == 0) mt = start ? 1 : 0;
         else if (mt < N + 3) mt++;
         else if (out_ready) mt = 0;
      end
      #1;
      check_output();
   endtask

   task automatic check_reset_outputs();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_clear", mac_clear, 0);
      check("rst_en", mac_en, 0);
      check("rst_last", mac_last, 0);
      check("rst_valid", out_valid, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_act", mac_act, 0);
      check("rst_weights", mac_weights, 0);
      check("rst_s_busy", s_busy, 0);
      check("rst_s_act", s_act, 0);
      check("rst_s_weights", s_weights, 0);
   endtask

   initial begin
      logic [7:0] b;

      // The ROM word for feature k holds byte k in every lane. The activation for k is k+1.
      for (int k = 0; k < N; k++) begin
         b = 8'(k);
         rom_mem[k] = {NN{b}};
         act_mem[k] = 8'(k + 1);
      end

      tbl[0]  = '{1, 0, 1, 1, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 0, 1, 0, 1, 1, 0, 0};
      tbl[3]  = '{0, 0, 1, 0, 0, 0, 1, 0};
      tbl[4]  = '{0, 0, 1, 0, 0, 0, 1, 0};
      tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 1};
      tbl[6]  = '{1, 1, 1, 1, 0, 0, 0, 0};
      tbl[7]  = '{0, 1, 1, 0, 0, 0, 0, 0};
      tbl[8]  = '{0, 1, 1, 0, 1, 1, 0, 0};
      tbl[9]  = '{0, 1, 1, 0, 0, 0, 1, 0};
      tbl[10] = '{0, 1, 0, 0, 0, 0, 0, 1};
      tbl[11] = '{0, 1, 0, 0, 0, 0, 0, 0};

      // Reset state.
      #3;
      check_reset_outputs();
      step();
      step();
      rst_n = 1'b1;
      step();

      // One full pass with out_ready high, carrying the byte-pattern ROM.
      start = 1'b1; out_ready = 1'b1;
      step();
      start = 1'b0;
      repeat (22) step();

      // The consumer stalls for 10 cycles once the result is valid.
      start = 1'b1; out_ready = 1'b0;
      step();
      start = 1'b0;
      repeat (N + 2) step();
      repeat (10) step();
      out_ready = 1'b1;
      step();
      step();

      // A start during RUN is ignored. A start in the done cycle launches a new pass.
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (N - 3) step();
      step();
      check("done_cycle_model", mdone, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (N + 4) step();

      // Reset is asserted in the middle of RUN. A fresh pass then runs to completion.
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      mt = 0;
      mdone = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (3) step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (N + 4) step();

      // Table-driven checks of the single-feature build.
      for (int i = 0; i < 12; i++) begin
         s_start = tbl[i].start;
         s_ready = tbl[i].ready;
         step();
         check($sformatf("s_busy[%0d]", i), s_busy, tbl[i].busy);
         check($sformatf("s_clear[%0d]", i), s_clear, tbl[i].clear);
         check($sformatf("s_en[%0d]", i), s_en, tbl[i].en);
         check($sformatf("s_last[%0d]", i), s_last, tbl[i].last);
         check($sformatf("s_valid[%0d]", i), s_valid, tbl[i].valid);
         check($sformatf("s_done[%0d]", i), s_done, tbl[i].done);
         check($sformatf("s_rom_addr[%0d]", i), s_rom_addr, 0);
         if (tbl[i].en) begin
            check($sformatf("s_act[%0d]", i), s_act, 8'h5E);
            check($sformatf("s_weights[%0d]", i), s_weights, 32'hA1B2_C3D4);
         end
      end
      s_start = 1'b0;
      s_ready = 1'b0;

      // Random ROM contents, then random start and out_ready traffic.
      for (int k = 0; k < N; k++) begin
         rom_mem[k] = {$urandom, $urandom, $urandom, $urandom};
         act_mem[k] = 8'($urandom);
      end
      for (int c = 0; c < 800; c++) begin
         start     = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
